// File: rtl/gpio_input_debounce.sv
// Per-bit synchronizer plus stability-window debouncer for board buttons and switches.
// Each bit independently reports its debounced level and one-cycle rise/fall pulses.
module gpio_input_debounce #(
  parameter int WIDTH       = 5,
  parameter int CNT_MAX     = 1000000,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] raw_i,
  output logic [WIDTH-1:0] db_o,
  output logic [WIDTH-1:0] rise_o,
  output logic [WIDTH-1:0] fall_o,
  output logic             change_o
);

  localparam int CW = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CNT_MAX - 1);

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] sync;
  logic [CW-1:0]    cnt      [WIDTH];
  logic [CW-1:0]    cnt_next [WIDTH];
  logic [WIDTH-1:0] pending;
  logic [WIDTH-1:0] done;
  logic [WIDTH-1:0] rise_next;
  logic [WIDTH-1:0] fall_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
    end else begin
      sync_q[0] <= raw_i;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
    end
  end

  assign sync = sync_q[SYNC_STAGES-1];

  // Per-bit state is never stored: a bit is PENDING exactly when sync disagrees with db.
  assign pending = sync ^ db_o;

  always_comb begin
    done = '0;
    for (int b = 0; b < WIDTH; b++) begin
      cnt_next[b] = '0;
      if (pending[b]) begin
        if (cnt[b] == CNT_LAST) begin
          done[b] = 1'b1;
        end else begin
          cnt_next[b] = cnt[b] + CW'(1);
        end
      end
    end
    rise_next = done & sync;
    fall_next = done & ~sync;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int b = 0; b < WIDTH; b++) cnt[b] <= '0;
      db_o     <= '0;
      rise_o   <= '0;
      fall_o   <= '0;
      change_o <= 1'b0;
    end else begin
      for (int b = 0; b < WIDTH; b++) cnt[b] <= cnt_next[b];
      db_o     <= db_o ^ done;
      rise_o   <= rise_next;
      fall_o   <= fall_next;
      change_o <= |done;
    end
  end

endmodule

// File: tb/tb_gpio_input_debounce.sv
// Bench for gpio_input_debounce: directed scenarios with literal expectations, then random
// stimulus, all checked every cycle against a sliding-window model of the debounce rule.
module tb_gpio_input_debounce;

  localparam int WIDTH       = 5;
  localparam int CNT_MAX     = 4;
  localparam int SYNC_STAGES = 2;

  logic             clk = 1'b0;
  logic             reset;
  logic [WIDTH-1:0] raw;
  logic [WIDTH-1:0] db;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic             change;

  int n_cmp = 0;
  int n_bad = 0;

  gpio_input_debounce #(
    .WIDTH(WIDTH), .CNT_MAX(CNT_MAX), .SYNC_STAGES(SYNC_STAGES)
  ) dut (
    .clk(clk), .reset(reset), .raw_i(raw),
    .db_o(db), .rise_o(rise), .fall_o(fall), .change_o(change)
  );

  always #5 clk = ~clk;

  // Model: history of what each edge sampled; db flips once the last CNT_MAX synchronized
  // samples all disagree with it.
  logic [WIDTH-1:0] raw_hist[$];
  bit               rst_hist[$];
  logic [WIDTH-1:0] m_db = '0, m_rise = '0, m_fall = '0, m_flip;
  logic             m_change = 1'b0;
  int               n_edges = 0;

  function automatic logic [WIDTH-1:0] sync_at(int j);
    if (j < SYNC_STAGES - 1) return '0;
    for (int d = 0; d < SYNC_STAGES; d++) if (rst_hist[j-d]) return '0;
    return raw_hist[j-SYNC_STAGES+1];
  endfunction

  always @(posedge clk) begin
    int e;
    e = n_edges;
    raw_hist.push_back(raw);
    rst_hist.push_back(reset);
    n_edges = n_edges + 1;
    if (reset) begin
      m_db = '0; m_rise = '0; m_fall = '0; m_change = 1'b0;
    end else begin
      m_flip = '1;
      for (int j = e - CNT_MAX; j < e; j++) begin
        if (j < 0) m_flip = '0;
        else m_flip = m_flip & (sync_at(j) ^ m_db);
      end
      m_rise   = m_flip & ~m_db;
      m_fall   = m_flip & m_db;
      m_db     = m_db ^ m_flip;
      m_change = |m_flip;
    end
  end

  task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    n_cmp = n_cmp + 1;
    if (act !== exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s at t=%0t: got %b, expected %b", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (n_edges > 0) begin
      check("model_db", db, m_db);
      check("model_rise", rise, m_rise);
      check("model_fall", fall, m_fall);
      check("model_change", {{(WIDTH-1){1'b0}}, change}, {{(WIDTH-1){1'b0}}, m_change});
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic settle_zero();
    raw = '0;
    tick(12);
  endtask

  initial begin
    int pulses;
    int pos;
    reset = 1'b1;
    raw   = '0;
    tick(3);
    check("reset_db", db, 5'b00000);
    check("reset_rise", rise, 5'b00000);
    check("reset_change", {4'b0, change}, 5'b00000);
    reset = 1'b0;
    tick(1);
    check("deassert_change", {4'b0, change}, 5'b00000);

    // Clean step on bit 0: sampled on edge N, db changes on edge N+5.
    raw[0] = 1'b1;
    tick(5);
    check("step_db_before", db, 5'b00000);
    tick(1);
    check("step_db", db, 5'b00001);
    check("step_rise", rise, 5'b00001);
    check("step_change", {4'b0, change}, 5'b00001);
    tick(1);
    check("step_rise_gone", rise, 5'b00000);
    check("step_change_gone", {4'b0, change}, 5'b00000);
    settle_zero();

    // Glitch three cycles long on bit 1 is rejected.
    raw[1] = 1'b1;
    tick(3);
    raw[1] = 1'b0;
    tick(10);
    check("glitch_db", db, 5'b00000);

    // Bounce on bit 2, then a steady 1.
    for (int i = 0; i < 10; i++) begin
      raw[2] = (i % 2 == 0);
      tick(1);
    end
    raw[2] = 1'b1;
    pulses = 0;
    pos    = 0;
    for (int i = 1; i <= 15; i++) begin
      tick(1);
      if (rise[2]) begin
        pulses = pulses + 1;
        pos    = i;
      end
    end
    check("bounce_pulses", 5'(pulses), 5'd1);
    check("bounce_pos", 5'(pos), 5'd6);
    settle_zero();

    // Several bits at once.
    raw = 5'b10101;
    tick(5);
    check("simul_db_before", db, 5'b00000);
    tick(1);
    check("simul_db", db, 5'b10101);
    check("simul_rise", rise, 5'b10101);
    check("simul_change", {4'b0, change}, 5'b00001);
    tick(1);
    check("simul_change_gone", {4'b0, change}, 5'b00000);
    settle_zero();

    // Reset during a count on bit 3.
    raw[3] = 1'b1;
    tick(4);
    reset = 1'b1;
    tick(1);
    check("midrst_db", db, 5'b00000);
    check("midrst_rise", rise, 5'b00000);
    reset = 1'b0;
    tick(5);
    check("midrst_db_before", db, 5'b00000);
    tick(1);
    check("midrst_rise_after", rise, 5'b01000);
    check("midrst_db_after", db, 5'b01000);
    settle_zero();

    // Release on bit 4.
    raw[4] = 1'b1;
    tick(12);
    check("release_db_high", db, 5'b10000);
    raw[4] = 1'b0;
    tick(5);
    check("release_db_before", db, 5'b10000);
    tick(1);
    check("release_fall", fall, 5'b10000);
    check("release_rise", rise, 5'b00000);
    tick(1);
    check("release_fall_gone", fall, 5'b00000);

    // Random stimulus with occasional short resets.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      reset = ($urandom_range(0, 249) == 0);
      for (int b = 0; b < WIDTH; b++)
        if ($urandom_range(0, 9) == 0) raw[b] = ~raw[b];
    end
    reset = 1'b0;
    tick(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/gpio_input_debounce.md
GPIO_INPUT_DEBOUNCE -- requirements
Module: gpio_input_debounce

Interface
REQ-001 The block SHALL have exactly one clock and one reset; reset SHALL be synchronous and active-high.
REQ-002 Parameter WIDTH, default 5, SHALL set the number of independent input bits (push buttons; 16 for DIP switches).
REQ-003 Parameter CNT_MAX, default 1000000, SHALL set the stability window in clk cycles (10 ms at 100 MHz); legal range 2 to 2^24.
REQ-004 Parameter SYNC_STAGES, default 2, SHALL set the synchronizer depth; legal range 2 to 4.
REQ-005 Port: clk  input  1  system clock; all flops rise-edge.
REQ-006 Port: reset  input  1  synchronous active-high reset.
REQ-007 Port: raw_i  input  WIDTH  asynchronous board inputs (buttons/switches).
REQ-008 Port: db_o  output  WIDTH  debounced level; drives the GPIO tri_i input of the processor subsystem.
REQ-009 Port: rise_o  output  WIDTH  one-cycle pulse per bit on a debounced 0->1.
REQ-010 Port: fall_o  output  WIDTH  one-cycle pulse per bit on a debounced 1->0.
REQ-011 Port: change_o  output  1  one-cycle pulse, OR of all rise_o and fall_o bits in the same cycle.

Function
REQ-012 Each bit SHALL pass through a SYNC_STAGES-deep flop chain; only the last stage (sync) SHALL feed the debounce logic.
REQ-013 Each bit SHALL own an independent counter of width clog2(CNT_MAX); bits SHALL NOT share counters or state.
REQ-014 Per bit, two states SHALL exist: STABLE (sync == db) and PENDING (sync != db); the state SHALL be derived from comparing sync with db, not stored separately.
REQ-015 In STABLE, the counter SHALL be held at 0.
REQ-016 In PENDING with counter < CNT_MAX-1, the counter SHALL increment by 1 per edge.
REQ-017 In PENDING with counter == CNT_MAX-1, db SHALL take the sync value on that edge and the counter SHALL clear to 0.
REQ-018 If sync returns to db before the count completes, the counter SHALL clear to 0 on the next edge and db SHALL NOT change; no partial credit SHALL be kept.
REQ-019 Latency: for a clean step first sampled on edge N, db_o SHALL change on edge N + SYNC_STAGES + CNT_MAX - 1.
REQ-020 rise_o/fall_o SHALL assert in the same cycle db_o changes and SHALL last exactly one cycle.
REQ-021 change_o SHALL be registered with rise_o/fall_o, so all three pulse in the same cycle.
REQ-022 Simultaneous transitions on several bits SHALL produce per-bit pulses in the same cycle and a single change_o pulse.
REQ-023 The counter SHALL never exceed CNT_MAX-1 and SHALL never wrap.
REQ-024 rise_o and fall_o for one bit SHALL never assert in the same cycle.

Reset
REQ-025 While reset is high, all synchronizer flops, counters, db_o, rise_o, fall_o and change_o SHALL be 0 on every edge.
REQ-026 Reset asserted mid-count SHALL abandon the count; no pulse SHALL be emitted for it.
REQ-027 An input held at 1 through reset SHALL produce db_o=1 and a rise_o pulse SYNC_STAGES + CNT_MAX - 1 edges after the first edge with reset low.
REQ-028 No output SHALL pulse in the cycle reset deasserts.

Verification (WIDTH=5, CNT_MAX=4, SYNC_STAGES=2)
REQ-029 Clean step: raw_i[0] 0->1 sampled at edge 10 -> db_o[0]=1 after edge 15; rise_o[0] and change_o high for that one cycle only.
REQ-030 Glitch reject: raw_i[1] high for 3 cycles then low -> db_o[1] stays 0; rise_o, fall_o, change_o stay 0 throughout.
REQ-031 Bounce: raw_i[2] toggles every cycle for 10 cycles, then holds 1 -> exactly one rise_o[2] pulse, 5 edges after the first edge sampling the final 1.
REQ-032 Simultaneous: raw_i 00000->10101 at one edge -> db_o=10101 on a single edge; rise_o=10101; change_o single pulse.
REQ-033 Reset mid-operation: raw_i[3] rises, reset pulses at count 2 -> no pulse during reset; rise_o[3] 5 edges after reset deasserts.
REQ-034 Release: from db_o[4]=1, raw_i[4] falls -> fall_o[4] single pulse 5 edges later; rise_o[4] stays 0.
